// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF challenge sequencer: walks 8 LFSR challenges, fires a race pulse per
// challenge and collects the synchronized responses into a byte. Optional PUF_MAJORITY_VOTE_EN.
module puf_challenge_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int PULSE_WIDTH   = 2,
  parameter int CAPTURE_DELAY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] seed,
  output logic [7:0] puf_challenge,
  output logic       puf_pulse,
  input  logic       puf_response,
  output logic [7:0] resp_byte,
  output logic       resp_valid,
  output logic       busy,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {IDLE, SETTLE, PULSE, CAPTURE, DONE} state_e;

  localparam logic [7:0] S_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] P_LAST = 8'(PULSE_WIDTH - 1);
  localparam logic [7:0] C_LAST = 8'(CAPTURE_DELAY - 1);

  // Handshake: start is a level; it is taken only in IDLE once reset release is
  // synchronized, and ignored otherwise. resp_valid is a single-cycle strobe with no back-pressure.
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] chal_q, chal_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] resp_byte_q, resp_byte_d;
  logic       resp_valid_q, resp_valid_d;
  logic       pulse_q, pulse_d;
  logic [1:0] sync_q, sync_d;
  logic [1:0] rst_ok_q, rst_ok_d;
  logic       commit;
  logic       bit_val;
`ifdef PUF_MAJORITY_VOTE_EN
  logic [1:0] eval_q, eval_d;
  logic [1:0] votes_q, votes_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    chal_d       = chal_q;
    shift_d      = shift_q;
    resp_byte_d  = resp_byte_q;
    resp_valid_d = 1'b0;
    sync_d       = {sync_q[0], puf_response};
    rst_ok_d     = {rst_ok_q[0], 1'b1};
    commit       = 1'b0;
    bit_val      = sync_q[1];
`ifdef PUF_MAJORITY_VOTE_EN
    eval_d       = eval_q;
    votes_d      = votes_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && rst_ok_q[1]) begin
          chal_d    = (seed == 8'h00) ? 8'h01 : seed;
          bit_cnt_d = 3'd0;
          cnt_d     = 8'd0;
          shift_d   = 8'h00;
`ifdef PUF_MAJORITY_VOTE_EN
          eval_d    = 2'd0;
`endif
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == S_LAST) begin
          cnt_d   = 8'd0;
          state_d = PULSE;
        end else cnt_d = cnt_q + 8'd1;
      end
      PULSE: begin
        if (cnt_q == P_LAST) begin
          cnt_d   = 8'd0;
          state_d = CAPTURE;
        end else cnt_d = cnt_q + 8'd1;
      end
      CAPTURE: begin
        if (cnt_q == C_LAST) begin
          cnt_d = 8'd0;
`ifdef PUF_MAJORITY_VOTE_EN
          if (eval_q == 2'd2) begin
            commit  = 1'b1;
            bit_val = (votes_q[0] & votes_q[1]) | (votes_q[0] & sync_q[1]) |
                      (votes_q[1] & sync_q[1]);
            eval_d  = 2'd0;
          end else begin
            votes_d[eval_q[0]] = sync_q[1];
            eval_d  = eval_q + 2'd1;
            state_d = SETTLE;
          end
`else
          commit = 1'b1;
`endif
          if (commit) begin
            shift_d[bit_cnt_q] = bit_val;
            if (bit_cnt_q == 3'd7) state_d = DONE;
            else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              chal_d    = {chal_q[6:0], chal_q[7] ^ chal_q[5] ^ chal_q[4] ^ chal_q[3]};
              state_d   = SETTLE;
            end
          end
        end else cnt_d = cnt_q + 8'd1;
      end
      DONE: begin
        resp_byte_d  = shift_q;
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Registered so the race pulse is glitch-free at the PUF inputs.
    pulse_d = (state_d == PULSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      bit_cnt_q    <= 3'd0;
      chal_q       <= 8'h00;
      shift_q      <= 8'h00;
      resp_byte_q  <= 8'h00;
      resp_valid_q <= 1'b0;
      pulse_q      <= 1'b0;
      sync_q       <= 2'b00;
      rst_ok_q     <= 2'b00;
`ifdef PUF_MAJORITY_VOTE_EN
      eval_q       <= 2'd0;
      votes_q      <= 2'b00;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      chal_q       <= chal_d;
      shift_q      <= shift_d;
      resp_byte_q  <= resp_byte_d;
      resp_valid_q <= resp_valid_d;
      pulse_q      <= pulse_d;
      sync_q       <= sync_d;
      rst_ok_q     <= rst_ok_d;
`ifdef PUF_MAJORITY_VOTE_EN
      eval_q       <= eval_d;
      votes_q      <= votes_d;
`endif
    end
  end

  assign puf_challenge = chal_q;
  assign puf_pulse     = pulse_q;
  assign resp_byte     = resp_byte_q;
  assign resp_valid    = resp_valid_q;
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer: default-parameter instance plus a
// short-timing instance (S=1,P=1,C=3), each driven by an XOR-parity PUF model.
module tb_puf_challenge_sequencer;

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int EV = 3;
`else
  localparam int EV = 1;
`endif
  localparam int S_A = 4, P_A = 2, C_A = 3;
  localparam int S_B = 1, P_B = 1, C_B = 3;
  localparam int LAT_A = EV * 8 * (S_A + P_A + C_A) + 1;
  localparam int LAT_B = EV * 8 * (S_B + P_B + C_B) + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start_v;
  logic [7:0] seed_v [2];
  logic [7:0] chal_w [2];
  logic [7:0] rbyte_w [2];
  logic [2:0] dbg_w [2];
  logic [1:0] pulse_w, resp_in, valid_w, busy_w;
  logic [1:0] inv_v = 2'b00;
  logic [1:0] mon_en = 2'b00;

  logic [7:0] exp_chal [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
  int n_checks = 0, n_err = 0;
  int pulse_cnt [2] = '{0, 0};
  int vcnt [2] = '{0, 0};
  int stab [2] = '{0, 0};
  int hi [2] = '{0, 0};
  logic [7:0] prev_chal [2] = '{8'h00, 8'h00};
  logic [1:0] prev_pulse = 2'b00;

  always #5 clk = ~clk;

  assign resp_in[0] = ^chal_w[0] ^ inv_v[0];
  assign resp_in[1] = ^chal_w[1] ^ inv_v[1];

  puf_challenge_sequencer #(.SETTLE_CYCLES(S_A), .PULSE_WIDTH(P_A), .CAPTURE_DELAY(C_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .seed(seed_v[0]),
    .puf_challenge(chal_w[0]), .puf_pulse(pulse_w[0]), .puf_response(resp_in[0]),
    .resp_byte(rbyte_w[0]), .resp_valid(valid_w[0]), .busy(busy_w[0]), .dbg_state(dbg_w[0]));

  puf_challenge_sequencer #(.SETTLE_CYCLES(S_B), .PULSE_WIDTH(P_B), .CAPTURE_DELAY(C_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .seed(seed_v[1]),
    .puf_challenge(chal_w[1]), .puf_pulse(pulse_w[1]), .puf_response(resp_in[1]),
    .resp_byte(rbyte_w[1]), .resp_valid(valid_w[1]), .busy(busy_w[1]), .dbg_state(dbg_w[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pulse-width, settle-time and challenge-order monitor; also drives the PUF model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (chal_w[i] !== prev_chal[i]) stab[i] = 1;
      else stab[i]++;
      if (mon_en[i]) begin
        if (pulse_w[i] && !prev_pulse[i]) begin
          chk("settle_time", 32'((stab[i] - 1) >= ((i == 0) ? S_A : S_B)), 32'd1);
          if (pulse_cnt[i] / EV < 8)
            chk("challenge", 32'(chal_w[i]), 32'(exp_chal[pulse_cnt[i] / EV]));
          inv_v[i] = (EV == 3) && (pulse_cnt[i] % 3 == 1);
          pulse_cnt[i]++;
          hi[i] = 1;
        end else if (pulse_w[i]) hi[i]++;
        else if (prev_pulse[i]) chk("pulse_width", 32'(hi[i]), 32'((i == 0) ? P_A : P_B));
        if (valid_w[i]) vcnt[i]++;
      end else hi[i] = 0;
      prev_chal[i]  = chal_w[i];
      prev_pulse[i] = pulse_w[i];
    end
  end

  task automatic run_one(input int i, input logic [7:0] sd, input int lat, input bit poke,
                         input bit hold);
    @(negedge clk);
    seed_v[i]    = sd;
    start_v[i]   = 1'b1;
    pulse_cnt[i] = 0;
    vcnt[i]      = 0;
    @(posedge clk);
    @(negedge clk);
    start_v[i] = hold;
    chk("busy_after_start", 32'(busy_w[i]), 32'd1);
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!hold) start_v[i] = poke && (k >= 5) && (k <= 70) && (k % 7 == 0);
      if (k == lat - 1) chk("valid_early", 32'(valid_w[i]), 32'd0);
      if (k == lat) begin
        chk("valid_at_lat", 32'(valid_w[i]), 32'd1);
        chk("resp_byte", 32'(rbyte_w[i]), 32'h2F);
      end
      if (k == lat + 1) begin
        chk("valid_one_cycle", 32'(valid_w[i]), 32'd0);
        chk("resp_hold", 32'(rbyte_w[i]), 32'h2F);
        chk("busy_end", 32'(busy_w[i]), 32'(hold));
        chk("valid_count", 32'(vcnt[i]), 32'd1);
      end
    end
    if (hold) begin
      start_v[i] = 1'b0;
      repeat (lat + 2) @(negedge clk);
      chk("hold_restart_valid", 32'(vcnt[i]), 32'd2);
      chk("hold_restart_byte", 32'(rbyte_w[i]), 32'h2F);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst_n      = 1'b0;
    start_v    = 2'b00;
    seed_v[0]  = 8'h00;
    seed_v[1]  = 8'h00;
    #1;
    chk("rst_chal", 32'(chal_w[0]), 32'h00);
    chk("rst_pulse", 32'(pulse_w[0]), 32'd0);
    chk("rst_byte", 32'(rbyte_w[0]), 32'h00);
    chk("rst_valid", 32'(valid_w[0]), 32'd0);
    chk("rst_busy", 32'(busy_w), 32'd0);
    #21 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 2'b11;

    run_one(0, 8'h01, LAT_A, 1'b0, 1'b0);
    run_one(0, 8'h00, LAT_A, 1'b0, 1'b0);
    run_one(0, 8'h01, LAT_A, 1'b1, 1'b0);
    run_one(0, 8'h01, LAT_A, 1'b0, 1'b1);

    // Abort a run during the 4th race pulse.
    @(negedge clk);
    seed_v[0] = 8'h01; start_v[0] = 1'b1; pulse_cnt[0] = 0; vcnt[0] = 0;
    @(negedge clk);
    start_v[0] = 1'b0;
    guard = 0;
    while (pulse_cnt[0] < 4 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_pulse4", 32'(guard < 500), 32'd1);
    chk("pulse4_high", 32'(pulse_w[0]), 32'd1);
    #2;
    mon_en[0] = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("abort_pulse", 32'(pulse_w[0]), 32'd0);
    chk("abort_chal", 32'(chal_w[0]), 32'h00);
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    chk("abort_state", 32'(dbg_w[0]), 32'd0);
    chk("abort_byte", 32'(rbyte_w[0]), 32'h00);
    #10 rst_n = 1'b1;
    @(negedge clk);
    mon_en[0] = 1'b1;
    repeat (100) @(negedge clk);
    chk("abort_no_valid", 32'(vcnt[0]), 32'd0);
    chk("abort_idle", 32'(busy_w[0]), 32'd0);
    run_one(0, 8'h01, LAT_A, 1'b0, 1'b0);

    run_one(1, 8'h01, LAT_B, 1'b0, 1'b0);
    run_one(1, 8'h00, LAT_B, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/puf_challenge_sequencer.md
PUF_CHALLENGE_SEQUENCER -- requirements
Module: puf_challenge_sequencer

Interface
REQ-001 SETTLE_CYCLES, 4, cycles a challenge is held stable before the pulse (legal range 1..255).
REQ-002 PULSE_WIDTH, 2, cycles the race pulse is held high (legal range 1..255).
REQ-003 CAPTURE_DELAY, 3, cycles from pulse fall to response sampling (legal range 3..255; covers the 2-flop synchronizer).
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 start  input  1  level-sampled request to run one 8-challenge sequence.
REQ-007 seed  input  8  initial challenge, captured when start is accepted.
REQ-008 puf_challenge  output  8  challenge driven to the arbiter PUF selects.
REQ-009 puf_pulse  output  1  race pulse driven into both PUF delay-line inputs.
REQ-010 puf_response  input  1  PUF arbiter output; asynchronous to clk.
REQ-011 resp_byte  output  8  collected response bits, LSB = first challenge.
REQ-012 resp_valid  output  1  one-cycle strobe; resp_byte newly updated.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE, PULSE, CAPTURE and DONE.
REQ-015 IDLE with start=1: load challenge register with seed (8'h00 substituted by 8'h01), clear bit_cnt, go to SETTLE.
REQ-016 SETTLE: puf_pulse=0; after exactly SETTLE_CYCLES cycles go to PULSE.
REQ-017 PULSE: puf_pulse=1; after exactly PULSE_WIDTH cycles go to CAPTURE.
REQ-018 CAPTURE: puf_pulse=0; the synchronized puf_response is sampled on the last of CAPTURE_DELAY cycles into resp shift register bit [bit_cnt].
REQ-019 At the end of CAPTURE: bit_cnt==7 goes to DONE; otherwise bit_cnt increments, the challenge advances one LFSR step and the FSM goes to SETTLE.
REQ-020 LFSR step: next = {c[6:0], c[7]^c[5]^c[4]^c[3]}; seed 8'h01 yields challenges 01,02,04,08,11,23,47,8E.
REQ-021 DONE lasts one cycle: resp_byte is loaded from the shift register, resp_valid=1, next state IDLE.
REQ-022 Latency: resp_valid SHALL assert 8*(SETTLE_CYCLES+PULSE_WIDTH+CAPTURE_DELAY)+1 cycles after the edge accepting start (73 with defaults).
REQ-023 start while busy=1 SHALL be ignored; no queuing.
REQ-024 start held high continuously SHALL begin a new sequence on the cycle after DONE.
REQ-025 puf_challenge SHALL change only on the SETTLE entry edge, never during PULSE or CAPTURE.
REQ-026 resp_byte SHALL hold its value until the next DONE.
REQ-027 puf_response SHALL pass through exactly two clk flops before any use.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, puf_pulse=0, puf_challenge=8'h00, resp_byte=8'h00, resp_valid=0, busy=0, and clear counters and synchronizer flops.
REQ-029 Reset mid-sequence SHALL discard partial results; resp_valid SHALL NOT assert for the aborted run.
REQ-030 Release SHALL be synchronized; the first start is accepted no earlier than the second clk edge after rst_n rises.

Configuration
REQ-031 Macro PUF_MAJORITY_VOTE_EN defined: each challenge runs SETTLE/PULSE/CAPTURE three times, and the stored bit is the majority of the three samples; latency becomes 24*(S+P+C)+1.
REQ-032 PUF_MAJORITY_VOTE_EN undefined: single evaluation per challenge, vote logic absent, REQ-022 latency applies.

Verification
REQ-033 Reset, then seed=8'h01 with start pulse; PUF model response = XOR of challenge bits -> challenges 01,02,04,08,11,23,47,8E in order, resp_byte=8'h2F, resp_valid high exactly 1 cycle at cycle 73.
REQ-034 seed=8'h00 -> first challenge 8'h01, same result 8'h2F.
REQ-035 start re-pulsed during cycles 5..70 of a run -> no restart, single resp_valid, challenge order unchanged.
REQ-036 rst_n pulsed low during the 4th PULSE -> outputs at reset values within the same cycle, no resp_valid; a new start then gives 8'h2F.
REQ-037 PUF_MAJORITY_VOTE_EN defined, model inverting the 2nd of each 3 evaluations -> resp_byte=8'h2F at cycle 217.
REQ-038 Check puf_pulse width = PULSE_WIDTH and challenge stable >= SETTLE_CYCLES before every rising pulse, with defaults and with S=1,P=1,C=3.
